// File: rtl/fs_stream_pkg.sv
// Shared definitions for the transfer framer: header layout, FSM encodings and
// the header-beat builder used by the output side.
package fs_stream_pkg;

    localparam logic [7:0] MAGIC     = 8'hA5;
    localparam int         BURST_LEN = 16;

    localparam int HDR_MAGIC_LSB = 56;
    localparam int HDR_SEQ_LSB   = 32;
    localparam int HDR_IDX_LSB   = 24;
    localparam int HDR_LEN_LSB   = 16;

    localparam logic [1:0] IN_WAIT    = 2'd0;
    localparam logic [1:0] IN_FILL    = 2'd1;
    localparam logic [1:0] IN_DISCARD = 2'd2;

    localparam logic [1:0] OUT_IDLE = 2'd0;
    localparam logic [1:0] OUT_HDR  = 2'd1;
    localparam logic [1:0] OUT_DATA = 2'd2;

    typedef struct packed {
        logic [15:0] seq;
        logic [6:0]  idx;
    } hdr_entry_t;

    function automatic logic [63:0] build_header(input hdr_entry_t e);
        logic [63:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 8] = MAGIC;
        h[HDR_SEQ_LSB +: 16]  = e.seq;
        h[HDR_IDX_LSB +: 7]   = e.idx;
        h[HDR_LEN_LSB +: 8]   = 8'(BURST_LEN);
        return h;
    endfunction

endpackage

// File: rtl/transfer_framer_commit_fifo.sv
// Data buffer with speculative writes: words become visible to the reader only
// once committed, and an uncommitted burst can be rolled back in one cycle.
module commit_fifo #(
    parameter int DATA_W     = 64,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                commit_i,
    input  logic                rollback_i,
    input  logic                rd_en_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic [DEPTH_LOG2:0] level_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, cm_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0] wr_base, wr_ptr_d;

    // A rollback and a fresh write can share a cycle: the write lands at the
    // committed pointer, so the aborted words are simply overwritten later.
    assign wr_base  = rollback_i ? cm_ptr_q : wr_ptr_q;
    assign wr_ptr_d = wr_base + {{DEPTH_LOG2{1'b0}}, wr_en_i};

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_base[DEPTH_LOG2-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            cm_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            if (commit_i) begin
                cm_ptr_q <= wr_ptr_d;
            end
            if (rd_en_i) begin
                rd_ptr_q <= rd_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
            end
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign level_o   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/transfer_framer.sv
// Collects 16-word channel bursts from data_transfer, validates them and emits
// each as an AXI4-Stream frame of one header beat plus 16 data beats.
module transfer_framer
    import fs_stream_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int IDX_W          = 7,
    parameter int CNT_W          = 4,
    parameter int DEPTH_LOG2     = 6,
    parameter int HDR_DEPTH_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_out,
    input  logic [IDX_W-1:0]  data_index,
    input  logic [CNT_W-1:0]  data_count,
    input  logic              data_valid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [31:0]       frame_count,
    output logic [15:0]       drop_count,
    output logic [15:0]       err_count,
    output logic              busy
);

    localparam int BURST     = 1 << CNT_W;
    localparam int HDR_DEPTH = 1 << HDR_DEPTH_LOG2;
    localparam int SPACE_MAX = (1 << DEPTH_LOG2) - BURST;
    localparam logic [CNT_W-1:0] LAST_CNT = '1;

    logic [1:0]          in_state_q, in_state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    expect_q, expect_d;
    logic [15:0]         seq_q, seq_d;
    logic [15:0]         drop_q, err_q;
    logic [31:0]         frame_q;
    logic [1:0]          out_state_q, out_state_d;
    logic [CNT_W-1:0]    beat_q, beat_d;

    hdr_entry_t                hdr_mem_q [HDR_DEPTH];
    logic [HDR_DEPTH_LOG2:0]   hdr_wr_q, hdr_rd_q;
    logic                      hdr_full, hdr_empty;
    hdr_entry_t                hdr_new, hdr_head;

    logic                wr_en, commit, rollback, rd_en;
    logic                hdr_push, hdr_pop;
    logic                drop_inc, err_inc, frame_inc;
    logic                eval_start, space_ok;
    logic [DATA_W-1:0]   fifo_rd_data;
    logic [DEPTH_LOG2:0] level;

    commit_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_data_i  (data_out),
        .commit_i   (commit),
        .rollback_i (rollback),
        .rd_en_i    (rd_en),
        .rd_data_o  (fifo_rd_data),
        .level_o    (level)
    );

    assign hdr_empty = (hdr_wr_q == hdr_rd_q);
    assign hdr_full  = (hdr_wr_q[HDR_DEPTH_LOG2] != hdr_rd_q[HDR_DEPTH_LOG2]) &&
                       (hdr_wr_q[HDR_DEPTH_LOG2-1:0] == hdr_rd_q[HDR_DEPTH_LOG2-1:0]);
    assign space_ok  = (32'(level) <= 32'(SPACE_MAX));
    assign hdr_new   = '{seq: seq_q, idx: idx_q};
    assign hdr_head  = hdr_mem_q[hdr_rd_q[HDR_DEPTH_LOG2-1:0]];

    // Input side: a word with count 0 always starts a fresh evaluation, even
    // when it interrupts a burst that was still filling.
    always_comb begin
        in_state_d = in_state_q;
        idx_d      = idx_q;
        expect_d   = expect_q;
        seq_d      = seq_q;
        wr_en      = 1'b0;
        commit     = 1'b0;
        rollback   = 1'b0;
        hdr_push   = 1'b0;
        drop_inc   = 1'b0;
        err_inc    = 1'b0;
        eval_start = 1'b0;
        if (data_valid) begin
            case (in_state_q)
                IN_FILL: begin
                    if (data_count == expect_q && data_index == idx_q) begin
                        wr_en    = 1'b1;
                        expect_d = expect_q + CNT_W'(1);
                        if (data_count == LAST_CNT) begin
                            commit     = 1'b1;
                            hdr_push   = 1'b1;
                            seq_d      = seq_q + 16'd1;
                            in_state_d = IN_WAIT;
                        end
                    end else begin
                        rollback = 1'b1;
                        err_inc  = 1'b1;
                        if (data_count == '0) begin
                            eval_start = 1'b1;
                        end else begin
                            in_state_d = IN_DISCARD;
                        end
                    end
                end
                IN_DISCARD: begin
                    eval_start = (data_count == '0);
                end
                default: begin
                    if (data_count == '0) begin
                        eval_start = 1'b1;
                    end else begin
                        err_inc    = 1'b1;
                        in_state_d = IN_DISCARD;
                    end
                end
            endcase
            if (eval_start) begin
                if (space_ok && !hdr_full) begin
                    wr_en      = 1'b1;
                    idx_d      = data_index;
                    expect_d   = CNT_W'(1);
                    in_state_d = IN_FILL;
                end else begin
                    drop_inc   = 1'b1;
                    in_state_d = IN_DISCARD;
                end
            end
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        beat_d      = beat_q;
        hdr_pop     = 1'b0;
        rd_en       = 1'b0;
        frame_inc   = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (!hdr_empty) begin
                    out_state_d = OUT_HDR;
                end
            end
            OUT_HDR: begin
                if (m_axis_tready) begin
                    hdr_pop     = 1'b1;
                    beat_d      = '0;
                    out_state_d = OUT_DATA;
                end
            end
            OUT_DATA: begin
                if (m_axis_tready) begin
                    rd_en  = 1'b1;
                    beat_d = beat_q + CNT_W'(1);
                    if (beat_q == LAST_CNT) begin
                        frame_inc   = 1'b1;
                        out_state_d = OUT_IDLE;
                    end
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (hdr_push) begin
            hdr_mem_q[hdr_wr_q[HDR_DEPTH_LOG2-1:0]] <= hdr_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q  <= IN_WAIT;
            idx_q       <= '0;
            expect_q    <= '0;
            seq_q       <= '0;
            drop_q      <= '0;
            err_q       <= '0;
            frame_q     <= '0;
            out_state_q <= OUT_IDLE;
            beat_q      <= '0;
            hdr_wr_q    <= '0;
            hdr_rd_q    <= '0;
        end else begin
            in_state_q  <= in_state_d;
            idx_q       <= idx_d;
            expect_q    <= expect_d;
            seq_q       <= seq_d;
            out_state_q <= out_state_d;
            beat_q      <= beat_d;
            if (hdr_push) begin
                hdr_wr_q <= hdr_wr_q + {{HDR_DEPTH_LOG2{1'b0}}, 1'b1};
            end
            if (hdr_pop) begin
                hdr_rd_q <= hdr_rd_q + {{HDR_DEPTH_LOG2{1'b0}}, 1'b1};
            end
            if (drop_inc && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
            if (err_inc && err_q != 16'hFFFF) begin
                err_q <= err_q + 16'd1;
            end
            if (frame_inc) begin
                frame_q <= frame_q + 32'd1;
            end
        end
    end

    assign m_axis_tvalid = (out_state_q != OUT_IDLE);
    assign m_axis_tlast  = (out_state_q == OUT_DATA) && (beat_q == LAST_CNT);
    assign m_axis_tdata  = (out_state_q == OUT_HDR) ? DATA_W'(build_header(hdr_head)) : fifo_rd_data;
    assign frame_count   = frame_q;
    assign drop_count    = drop_q;
    assign err_count     = err_q;
    assign busy          = (level != '0) || (out_state_q != OUT_IDLE);

endmodule

// File: tb/tb_transfer_framer.sv
// Directed bench for transfer_framer: a burst-level model predicts every output
// beat, and a negedge compare process checks beats and AXIS stall stability.
module tb_transfer_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] dataOut = '0;
    logic [6:0]  dataIndex = '0;
    logic [3:0]  dataCount = '0;
    logic        dataValid = 1'b0;
    logic [63:0] tdata;
    logic        tvalid, tlast;
    logic        tready = 1'b0;
    logic [31:0] frameCount;
    logic [15:0] dropCount, errCount;
    logic        busy;

    always #5 clk = ~clk;

    transfer_framer dut (
        .clk           (clk),
        .rst           (rst),
        .data_out      (dataOut),
        .data_index    (dataIndex),
        .data_count    (dataCount),
        .data_valid    (dataValid),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .frame_count   (frameCount),
        .drop_count    (dropCount),
        .err_count     (errCount),
        .busy          (busy)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        bit          isHdr;
    } beat_t;

    typedef enum int {mIdle, mFill, mDiscard} mode_t;

    beat_t       expQ[$];
    logic [63:0] burstBuf[$];
    logic [63:0] hdrSeen[$];
    beat_t       curBeat;
    mode_t       mode;
    int          checks = 0;
    int          failures = 0;
    int          committedWords, readsDone, hdrPushed, hdrPopped;
    int          nextCnt, framesSeen, framePos, beatsSeen;
    int          readyMode = 0;
    logic [6:0]  burstIdx;
    logic [15:0] modelSeq, modelDrop, modelErr;
    bit          hsData, hsHdr, prevStall;
    logic [63:0] prevData;
    logic        prevLast;

    function automatic logic [63:0] expectHeader(input logic [15:0] seq, input logic [6:0] idx);
        return {8'hA5, 8'h00, seq, 1'b0, idx, 8'd16, 16'h0000};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic clearModel();
        expQ.delete();
        burstBuf.delete();
        hdrSeen.delete();
        mode = mIdle;
        committedWords = 0;
        readsDone = 0;
        hdrPushed = 0;
        hdrPopped = 0;
        nextCnt = 0;
        framesSeen = 0;
        framePos = 0;
        beatsSeen = 0;
        burstIdx = '0;
        modelSeq = '0;
        modelDrop = '0;
        modelErr = '0;
        hsData = 1'b0;
        hsHdr = 1'b0;
        prevStall = 1'b0;
    endtask

    task automatic modelWord(input logic [6:0] idx, input logic [3:0] cnt, input logic [63:0] d);
        int  used;
        bit  startNew;
        beat_t b;
        used = committedWords + burstBuf.size() - readsDone;
        startNew = 0;
        if (mode == mFill) begin
            if (int'(cnt) == nextCnt && idx == burstIdx) begin
                burstBuf.push_back(d);
                nextCnt++;
                if (burstBuf.size() == 16) begin
                    b.data = expectHeader(modelSeq, burstIdx);
                    b.last = 1'b0;
                    b.isHdr = 1'b1;
                    expQ.push_back(b);
                    for (int i = 0; i < 16; i++) begin
                        b.data = burstBuf[i];
                        b.last = (i == 15);
                        b.isHdr = 1'b0;
                        expQ.push_back(b);
                    end
                    committedWords += 16;
                    hdrPushed++;
                    modelSeq++;
                    burstBuf.delete();
                    mode = mIdle;
                end
            end else begin
                burstBuf.delete();
                if (modelErr != 16'hFFFF) modelErr++;
                if (cnt == 4'd0) startNew = 1;
                else mode = mDiscard;
            end
        end else if (mode == mDiscard) begin
            if (cnt == 4'd0) startNew = 1;
        end else begin
            if (cnt == 4'd0) startNew = 1;
            else begin
                if (modelErr != 16'hFFFF) modelErr++;
                mode = mDiscard;
            end
        end
        if (startNew) begin
            if (64 - used >= 16 && hdrPushed - hdrPopped < 4) begin
                burstBuf.push_back(d);
                burstIdx = idx;
                nextCnt = 1;
                mode = mFill;
            end else begin
                if (modelDrop != 16'hFFFF) modelDrop++;
                mode = mDiscard;
            end
        end
    endtask

    // Model consumes the inputs seen at each edge, then retires the reads that
    // the compare process saw handshake at this same edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (dataValid) modelWord(dataIndex, dataCount, dataOut);
            readsDone += int'(hsData);
            hdrPopped += int'(hsHdr);
        end
    end

    always @(negedge clk) begin
        hsData = 1'b0;
        hsHdr = 1'b0;
        if (!rst) begin
            if (prevStall) begin
                checkOutput("validHeld", 64'(tvalid), 64'd1);
                checkOutput("dataStable", tdata, prevData);
                checkOutput("lastStable", 64'(tlast), 64'(prevLast));
            end
            if (tvalid && expQ.size() == 0) begin
                checkOutput("spuriousValid", 64'(tvalid), 64'd0);
            end else if (tvalid && tready) begin
                curBeat = expQ.pop_front();
                checkOutput("beatData", tdata, curBeat.data);
                checkOutput("beatLast", 64'(tlast), 64'(curBeat.last));
                if (curBeat.isHdr) begin
                    hsHdr = 1'b1;
                    hdrSeen.push_back(tdata);
                    framePos = 0;
                end else begin
                    hsData = 1'b1;
                end
                framePos++;
                beatsSeen++;
                if (tlast) framesSeen++;
            end
            prevStall = tvalid && !tready;
            prevData = tdata;
            prevLast = tlast;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: tready = 1'b1;
                1: tready = ~tready;
                default: tready = 1'b0;
            endcase
        end
    end

    task automatic pulseReset();
        rst = 1'b1;
        clearModel();
        #1;
        checkOutput("rstValid", 64'(tvalid), 64'd0);
        checkOutput("rstLast", 64'(tlast), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstFrames", 64'(frameCount), 64'd0);
        checkOutput("rstDrops", 64'(dropCount), 64'd0);
        checkOutput("rstErrs", 64'(errCount), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] idx, input int first, input int last, input logic [63:0] base);
        for (int c = first; c <= last; c++) begin
            dataIndex = idx;
            dataCount = 4'(c);
            dataOut = base + 64'(c);
            dataValid = 1'b1;
            @(posedge clk);
            #1;
        end
        dataValid = 1'b0;
    endtask

    task automatic waitDrained(input int maxCycles);
        bit done;
        done = 0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !busy) done = 1;
        end
        checkOutput("drained", 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit reached;
        @(posedge clk);
        #1;

        // Test 1: single clean burst, always ready
        readyMode = 0;
        pulseReset();
        applyStimulus(7'd5, 0, 15, 64'd0);
        waitDrained(200);
        checkOutput("t1Header", hdrSeen[0], 64'hA500_0000_0510_0000);
        checkOutput("t1Beats", 64'(beatsSeen), 64'd17);
        checkOutput("t1Frames", 64'(frameCount), 64'd1);
        checkOutput("t1FramesModel", 64'(frameCount), 64'(framesSeen));

        // Test 2: same burst with toggling ready
        readyMode = 1;
        pulseReset();
        applyStimulus(7'd5, 0, 15, 64'd0);
        waitDrained(200);
        checkOutput("t2Header", hdrSeen[0], 64'hA500_0000_0510_0000);
        checkOutput("t2Beats", 64'(beatsSeen), 64'd17);
        checkOutput("t2Frames", 64'(frameCount), 64'd1);

        // Test 3: buffer fills while stalled, fifth burst dropped
        readyMode = 2;
        pulseReset();
        for (int b = 0; b < 5; b++) begin
            applyStimulus(7'(b), 0, 15, {8'(b), 56'h0});
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t3Drops", 64'(dropCount), 64'd1);
        checkOutput("t3DropsModel", 64'(dropCount), 64'(modelDrop));
        checkOutput("t3Errs", 64'(errCount), 64'd0);
        readyMode = 0;
        waitDrained(400);
        checkOutput("t3Frames", 64'(frameCount), 64'd4);
        checkOutput("t3HdrCount", 64'(hdrSeen.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3HdrSeq", hdrSeen[i], expectHeader(16'(i), 7'(i)));
        end
        checkOutput("t3LastHdr", hdrSeen[3], 64'hA500_0003_0310_0000);

        // Test 4: channel switch mid-burst aborts it
        readyMode = 0;
        pulseReset();
        applyStimulus(7'd9, 0, 6, 64'h9000);
        applyStimulus(7'd10, 7, 15, 64'hA000);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t4Errs", 64'(errCount), 64'd1);
        checkOutput("t4NoFrame", 64'(tvalid), 64'd0);
        applyStimulus(7'd11, 0, 15, 64'hB000);
        waitDrained(200);
        checkOutput("t4Header", hdrSeen[0], 64'hA500_0000_0B10_0000);
        checkOutput("t4Frames", 64'(frameCount), 64'd1);
        checkOutput("t4ErrsModel", 64'(errCount), 64'(modelErr));

        // Test 5: burst restarts at count 0 after word 9
        pulseReset();
        applyStimulus(7'd2, 0, 9, 64'hC000);
        applyStimulus(7'd2, 0, 15, 64'hD000);
        waitDrained(200);
        checkOutput("t5Errs", 64'(errCount), 64'd1);
        checkOutput("t5Header", hdrSeen[0], 64'hA500_0000_0210_0000);
        checkOutput("t5Beats", 64'(beatsSeen), 64'd17);
        checkOutput("t5Frames", 64'(frameCount), 64'd1);

        // Test 6: reset lands while data beat 8 is presented
        applyStimulus(7'd3, 0, 15, 64'hE000);
        reached = 0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(negedge clk);
            if (framePos == 9) reached = 1;
        end
        checkOutput("t6Reached", 64'(reached), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("t6MidFrame", 64'(tvalid), 64'd1);
        pulseReset();
        applyStimulus(7'd6, 0, 15, 64'hF000);
        waitDrained(200);
        checkOutput("t6Header", hdrSeen[0], 64'hA500_0000_0610_0000);
        checkOutput("t6Frames", 64'(frameCount), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
